nickjhay_seq_ctrl: RTL
======================

# nickjhay_seq_ctrl

Command sequencer for the nickjhay processor datapath: accepts byte-wide commands over a valid/ready handshake and sequences a 4-entry register file and a shared ADD/XOR ALU through load, execute, readout and greeting ("HI") operations. It sits between the chip's pin-level I/O decode (ui_in/uio_in) and the register/ALU datapath, and serialises all datapath use so only one operation is in flight at a time. Results leave on a byte-wide valid/ready output port with backpressure.

## Interface
- DATA_W, 8: datapath and register width in bits
- NREG, 4: register count; fixed at 4, so register addresses are 2 bits
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE; a command is accepted on a rising edge with cmd_valid & cmd_ready
- cmd_op  in  2  opcode: 00 LOAD, 01 EXEC, 10 READ, 11 HI
- cmd_addr  in  2  LOAD destination register
- cmd_data  in  DATA_W  LOAD value; for EXEC, [5:4] dst, [3:2] srcA, [1:0] srcB; for READ, [1:0] source register
- usexor  in  1  sampled at EXEC accept: 1 = XOR, 0 = ADD
- out_valid  out  1  output byte present
- out_ready  in  1  consumer accepts on a rising edge with out_valid & out_ready
- out_data  out  DATA_W  output byte
- busy  out  1  state != IDLE
- flag_z  out  1  last EXEC result == 0
- flag_c  out  1  carry-out of last ADD; 0 after an XOR

## Operation
- States: IDLE, LOAD, EX_RD, EX_WB, OUT, HI1, HI2.
- IDLE: on accept, latch cmd_op/cmd_addr/cmd_data/usexor into internal registers, then go to LOAD, EX_RD, OUT or HI1 by opcode.
- LOAD: write the latched value to reg[cmd_addr] -> IDLE.
- EX_RD: latch operand A = reg[srcA] and operand B = reg[srcB] -> EX_WB.
- EX_WB: compute the result and write it to reg[dst]; update flag_z and flag_c -> IDLE.
  - ADD is modulo 2^DATA_W; flag_c is the carry-out (bit DATA_W).
  - XOR clears flag_c.
  - dst may equal srcA and/or srcB; the operands are the pre-write values.
- OUT: out_data = reg[addr], captured on entry; hold out_valid=1 until handshake -> IDLE.
- HI1: out_data = 0x48 until handshake -> HI2. HI2: out_data = 0x49 until handshake -> IDLE.
- out_data stays stable while out_valid=1 and out_ready=0.
- Registers change only in LOAD and EX_WB.
- Commands presented while busy are not accepted; cmd_valid is held by the producer.
- Reset, asserted at any time including mid-command:
  - state = IDLE; all registers = 0; flag_z = 1; flag_c = 0.
  - out_valid = 0 and out_data = 0, immediately and asynchronously.
  - Any in-flight command is discarded, with no partial write.

## Timing
- Reset values: cmd_ready=1, busy=0, out_valid=0, out_data=0, flag_z=1, flag_c=0.
- cmd_ready = !busy, decoded combinationally from state.
- LOAD: accept at edge N; register written at edge N+1; cmd_ready high again after edge N+1 (occupancy 1 cycle).
- EXEC: accept at N; operands latched at N+1; writeback and flags at N+2; cmd_ready high after N+2.
- READ: accept at N; out_valid high after N+1; stays high until the first edge with out_ready=1, then IDLE.
- With out_ready held high, READ occupies exactly 2 cycles; HI emits 0x48 and 0x49 on consecutive cycles, 3 cycles total.
- Back-to-back: a new command can be accepted on the first edge where cmd_ready=1. There are no bubbles beyond the per-op occupancy above.
- A LOAD followed by a READ of the same register returns the new value (the write completes before the READ is accepted).

## Test plan
- Reset, then LOAD r1=0x0F and LOAD r2=0xF1; EXEC ADD dst=r3, src=r1,r2 -> r3=0x00, flag_z=1, flag_c=1; READ r3 -> out_data=0x00.
- LOAD r0=0xAA, LOAD r1=0x55; EXEC XOR dst=r0, src=r0,r1 -> READ r0 = 0xFF, flag_z=0, flag_c=0; cmd_ready low for exactly 2 cycles after the EXEC accept.
- HI with out_ready=0 for 3 cycles, then 1 -> out_data holds 0x48 stable while stalled, then 0x49 for one cycle; busy drops after the second handshake.
- cmd_valid held high with a second READ while the first READ is stalled -> the second command is accepted only after the first output handshake; both bytes are correct and in order.
- Assert rst during EX_RD of an ADD to r2 -> immediately out_valid=0, busy=0; after release READ r2 = 0x00, flag_z=1, flag_c=0.
- EXEC ADD dst=r1, src=r1,r1 with r1=0x80 -> r1=0x00, flag_c=1, flag_z=1 (pre-write operands used).

Source files
------------

// File: rtl/nickjhay_seq_ctrl.sv
// Byte-wide command sequencer driving a 4-entry register file and a shared ADD/XOR ALU.
// One operation in flight at a time; results leave on a valid/ready byte port.
module nickjhay_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              rst,
  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // The producer holds valid and payload until that edge; the DUT holds out_valid/out_data
  // stable until the consumer takes the byte.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              usexor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_c,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EX_RD = 3'd2,
    S_EX_WB = 3'd3,
    S_OUT   = 3'd4,
    S_HI1   = 3'd5,
    S_HI2   = 3'd6
  } state_e;

  localparam logic [DATA_W-1:0] CHAR_H = DATA_W'(8'h48);
  localparam logic [DATA_W-1:0] CHAR_I = DATA_W'(8'h49);

  state_e            state_q;
  logic [1:0]        addr_q;
  logic [DATA_W-1:0] data_q;
  logic              xor_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] regs_q [NREG];

  logic [DATA_W:0]   sum_d;
  logic [DATA_W-1:0] res_d;

  assign sum_d     = {1'b0, opa_q} + {1'b0, opb_q};
  assign res_d     = xor_q ? (opa_q ^ opb_q) : sum_d[DATA_W-1:0];
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      xor_q     <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      flag_z    <= 1'b1;
      flag_c    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            data_q <= cmd_data;
            xor_q  <= usexor;
            case (cmd_op)
              2'b00:   state_q <= S_LOAD;
              2'b01:   state_q <= S_EX_RD;
              2'b10:   state_q <= S_OUT;
              default: state_q <= S_HI1;
            endcase
          end
        end
        S_LOAD: begin
          regs_q[addr_q] <= data_q;
          state_q        <= S_IDLE;
        end
        // Operands are captured before writeback, so dst may alias either source.
        S_EX_RD: begin
          opa_q   <= regs_q[data_q[3:2]];
          opb_q   <= regs_q[data_q[1:0]];
          state_q <= S_EX_WB;
        end
        S_EX_WB: begin
          regs_q[data_q[5:4]] <= res_d;
          flag_z              <= (res_d == '0);
          flag_c              <= xor_q ? 1'b0 : sum_d[DATA_W];
          state_q             <= S_IDLE;
        end
        S_OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= regs_q[data_q[1:0]];
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_HI1: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= CHAR_H;
          end else if (out_ready) begin
            out_data <= CHAR_I;
            state_q  <= S_HI2;
          end
        end
        S_HI2: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
